// File: rtl/ex_mem_flags_stage_if.sv
// ---------------------------------------------------------------------------
// ex_mem_flags_stage_if
//   Bundle of every signal between the EX stage and the EX/MEM flags stage,
//   apart from clock and reset.
//
//   master modport : upstream EX logic / hazard unit. It drives the
//                    instruction fields, stall and flush, and observes the
//                    registered EX/MEM slot, NZCV and redirect.
//   slave modport  : the ex_mem_flags_stage itself.
//
//   Inputs to the stage : stall, flush, in_valid, alu_d, alu flags,
//                         set_flags, branch type, cond, br_target, rd,
//                         control bundle, store_data
//   Outputs of the stage: mem_* slot, nzcv, branch_taken, branch_pc,
//                         squashing, br_taken_cnt, br_nt_cnt
// ---------------------------------------------------------------------------
interface ex_mem_flags_stage_if #(
  parameter int unsigned XLEN = 64
);
  // Upstream -> stage
  logic            stall;
  logic            flush;
  logic            in_valid;
  logic [XLEN-1:0] alu_d;
  logic            alu_cout;
  logic            alu_v;
  logic            alu_z;
  logic            alu_n;
  logic            set_flags;
  logic            is_bcond;
  logic            is_cbz;
  logic            is_cbnz;
  logic [3:0]      cond;
  logic [XLEN-1:0] br_target;
  logic [4:0]      rd;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] store_data;

  // Stage -> downstream
  logic            mem_valid;
  logic [XLEN-1:0] mem_alu_d;
  logic [4:0]      mem_rd;
  logic            mem_reg_write;
  logic            mem_mem_read;
  logic            mem_mem_write;
  logic [XLEN-1:0] mem_store_data;
  logic [3:0]      nzcv;
  logic            branch_taken;
  logic [XLEN-1:0] branch_pc;
  logic            squashing;
  logic [31:0]     br_taken_cnt;
  logic [31:0]     br_nt_cnt;

  modport master (
    output stall, flush, in_valid, alu_d, alu_cout, alu_v, alu_z, alu_n,
           set_flags, is_bcond, is_cbz, is_cbnz, cond, br_target, rd,
           reg_write, mem_read, mem_write, store_data,
    input  mem_valid, mem_alu_d, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_store_data, nzcv, branch_taken, branch_pc,
           squashing, br_taken_cnt, br_nt_cnt
  );

  modport slave (
    input  stall, flush, in_valid, alu_d, alu_cout, alu_v, alu_z, alu_n,
           set_flags, is_bcond, is_cbz, is_cbnz, cond, br_target, rd,
           reg_write, mem_read, mem_write, store_data,
    output mem_valid, mem_alu_d, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_store_data, nzcv, branch_taken, branch_pc,
           squashing, br_taken_cnt, br_nt_cnt
  );
endinterface

// File: rtl/ex_mem_flags_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_flags_stage
//   Execute-to-memory pipeline stage placed directly after the 64-bit ALU.
//   - Registers the ALU result and the control bundle into the EX/MEM slot.
//   - Holds the architectural NZCV register and resolves B.cond, CBZ and
//     CBNZ.
//   - Emits a single-cycle redirect pulse for a taken branch. It then drops
//     the next SQUASH_CYCLES valid wrong-path inputs.
//
// Parameters
//   SQUASH_CYCLES : valid input cycles dropped after a taken branch (1..7)
//   XLEN          : datapath width
//
// Ports
//   clk_i : clock, rising edge
//   rst_i : synchronous, active-high reset. It has priority over stall and
//           flush.
//   ex_if : ex_mem_flags_stage_if.slave. Carries the instruction input
//           bundle, the EX/MEM slot, NZCV, the redirect and the statistics.
//
// Optional feature
//   BRANCH_STATS_EN : when defined, builds the 32-bit taken / not-taken
//                     branch counters. When undefined, both count outputs
//                     are tied to zero.
// ---------------------------------------------------------------------------
module ex_mem_flags_stage #(
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter int unsigned XLEN          = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ex_mem_flags_stage_if.slave  ex_if
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

  // FSM
  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;

  // EX/MEM slot
  logic            mem_valid_q;
  logic [XLEN-1:0] mem_alu_d_q;
  logic [4:0]      mem_rd_q;
  logic            mem_reg_write_q;
  logic            mem_mem_read_q;
  logic            mem_mem_write_q;
  logic [XLEN-1:0] mem_store_data_q;

  // Flags and redirect
  logic [3:0]      nzcv_q;
  logic            branch_taken_q;
  logic [XLEN-1:0] branch_pc_q;

  // Decode helpers
  logic            acc_s;
  logic            zero_s;
  logic            cond_true_s;
  logic            take_s;
  logic            is_branch_s;

  // NZCV fields, in {N,Z,C,V} order
  logic            flag_n_s, flag_z_s, flag_c_s, flag_v_s;

  assign flag_n_s = nzcv_q[3];
  assign flag_z_s = nzcv_q[2];
  assign flag_c_s = nzcv_q[1];
  assign flag_v_s = nzcv_q[0];

  // An input is accepted only when the stage is not stalled, not flushed
  // and not dropping wrong-path instructions.
  assign acc_s = ex_if.in_valid & ~ex_if.stall & ~ex_if.flush &
                 (state_q == ST_IDLE);

  // CBZ/CBNZ compare the ALU result locally, without going through NZCV.
  assign zero_s      = (ex_if.alu_d == {XLEN{1'b0}});
  assign is_branch_s = ex_if.is_bcond | ex_if.is_cbz | ex_if.is_cbnz;

  // Condition-code evaluation against the current NZCV register
  always_comb begin
    cond_true_s = 1'b0;
    case (ex_if.cond)
      4'h0:    cond_true_s =  flag_z_s;                               // EQ
      4'h1:    cond_true_s = ~flag_z_s;                               // NE
      4'h2:    cond_true_s =  flag_c_s;                               // HS
      4'h3:    cond_true_s = ~flag_c_s;                               // LO
      4'h4:    cond_true_s =  flag_n_s;                               // MI
      4'h5:    cond_true_s = ~flag_n_s;                               // PL
      4'h6:    cond_true_s =  flag_v_s;                               // VS
      4'h7:    cond_true_s = ~flag_v_s;                               // VC
      4'h8:    cond_true_s =  flag_c_s & ~flag_z_s;                   // HI
      4'h9:    cond_true_s = ~(flag_c_s & ~flag_z_s);                 // LS
      4'hA:    cond_true_s =  (flag_n_s == flag_v_s);                 // GE
      4'hB:    cond_true_s =  (flag_n_s != flag_v_s);                 // LT
      4'hC:    cond_true_s = ~flag_z_s & (flag_n_s == flag_v_s);      // GT
      4'hD:    cond_true_s = ~(~flag_z_s & (flag_n_s == flag_v_s));   // LE
      4'hE:    cond_true_s = 1'b1;                                    // AL
      4'hF:    cond_true_s = 1'b1;                                    // NV behaves as AL
      default: cond_true_s = 1'b0;
    endcase
  end

  // Flush clears acc_s, so a flushed branch never redirects.
  assign take_s = acc_s & ((ex_if.is_bcond & cond_true_s) |
                           (ex_if.is_cbz   & zero_s)      |
                           (ex_if.is_cbnz  & ~zero_s));

  // Squash FSM next-state: count down valid unstalled inputs after a redirect
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          state_d = ST_SQUASH;
          cnt_d   = SQ_LOAD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      end
      ST_SQUASH: begin
        if (ex_if.stall) begin
          state_d = ST_SQUASH;
          cnt_d   = cnt_q;
        end else if (ex_if.flush) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (ex_if.in_valid) begin
          // The last dropped input returns the FSM to IDLE on the same edge.
          if (cnt_q <= 3'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end else begin
            state_d = ST_SQUASH;
            cnt_d   = cnt_q - 3'd1;
          end
        end else begin
          state_d = ST_SQUASH;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Squash FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX/MEM slot and redirect. A stall freezes the slot and clears the
  // redirect pulse so that it never repeats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_valid_q      <= 1'b0;
      mem_alu_d_q      <= {XLEN{1'b0}};
      mem_rd_q         <= 5'd0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_store_data_q <= {XLEN{1'b0}};
      branch_taken_q   <= 1'b0;
      branch_pc_q      <= {XLEN{1'b0}};
    end else if (ex_if.stall) begin
      branch_taken_q   <= 1'b0;
    end else begin
      mem_valid_q      <= acc_s;
      mem_alu_d_q      <= ex_if.alu_d;
      mem_rd_q         <= ex_if.rd;
      mem_reg_write_q  <= acc_s & ex_if.reg_write;
      mem_mem_read_q   <= acc_s & ex_if.mem_read;
      mem_mem_write_q  <= acc_s & ex_if.mem_write;
      mem_store_data_q <= ex_if.store_data;
      branch_taken_q   <= take_s;
      branch_pc_q      <= ex_if.br_target;
    end
  end

  // Architectural NZCV register, written only by accepted flag-setters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nzcv_q <= 4'd0;
    end else if (acc_s & ex_if.set_flags) begin
      nzcv_q <= {ex_if.alu_n, ex_if.alu_z, ex_if.alu_cout, ex_if.alu_v};
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_taken_cnt_q;
  logic [31:0] br_nt_cnt_q;

  // Branch statistics counters. Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_taken_cnt_q <= 32'd0;
      br_nt_cnt_q    <= 32'd0;
    end else begin
      if (take_s) begin
        br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
      end
      if (acc_s & is_branch_s & ~take_s) begin
        br_nt_cnt_q <= br_nt_cnt_q + 32'd1;
      end
    end
  end

  assign ex_if.br_taken_cnt = br_taken_cnt_q;
  assign ex_if.br_nt_cnt    = br_nt_cnt_q;
`else
  logic unused_stats_s;
  assign unused_stats_s     = is_branch_s;
  assign ex_if.br_taken_cnt = 32'd0;
  assign ex_if.br_nt_cnt    = 32'd0;
`endif

  assign ex_if.mem_valid      = mem_valid_q;
  assign ex_if.mem_alu_d      = mem_alu_d_q;
  assign ex_if.mem_rd         = mem_rd_q;
  assign ex_if.mem_reg_write  = mem_reg_write_q;
  assign ex_if.mem_mem_read   = mem_mem_read_q;
  assign ex_if.mem_mem_write  = mem_mem_write_q;
  assign ex_if.mem_store_data = mem_store_data_q;
  assign ex_if.nzcv           = nzcv_q;
  assign ex_if.branch_taken   = branch_taken_q;
  assign ex_if.branch_pc      = branch_pc_q;
  assign ex_if.squashing      = (state_q == ST_SQUASH);

endmodule

// File: tb/tb_ex_mem_flags_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_flags_stage
//   Directed testbench for ex_mem_flags_stage. A behavioural model tracks
//   the expected pipeline slot, the flags, the redirect and the number of
//   wrong-path inputs still to drop. Every output is compared against this
//   model on each negative clock edge. Literal expectations after key
//   vectors pin the model itself.
// ---------------------------------------------------------------------------
module tb_ex_mem_flags_stage;
  localparam int XLEN = 64;
  localparam int SQ   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_flags_stage_if #(.XLEN(XLEN)) bus ();

  ex_mem_flags_stage #(.SQUASH_CYCLES(SQ), .XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ex_if (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // ------------------------------ model ------------------------------
  logic            m_valid, m_rw, m_mr, m_mw, m_bt;
  logic [XLEN-1:0] m_alu, m_sd, m_bpc;
  logic [4:0]      m_rd;
  logic [3:0]      m_nzcv;
  int              m_sq;          // wrong-path inputs still to drop
  logic [31:0]     m_tc, m_ntc;

  // Evaluates a condition code with the family/invert split of the code space.
  function automatic logic m_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  logic m_acc, m_zero, m_take, m_isbr;
  assign m_acc  = bus.in_valid && !bus.stall && !bus.flush && (m_sq == 0);
  assign m_zero = (bus.alu_d == 64'd0);
  assign m_isbr = bus.is_bcond || bus.is_cbz || bus.is_cbnz;
  assign m_take = m_acc && ((bus.is_bcond && m_cond(m_nzcv, bus.cond)) ||
                            (bus.is_cbz && m_zero) || (bus.is_cbnz && !m_zero));

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_bt <= 1'b0;
      m_alu <= '0; m_sd <= '0; m_bpc <= '0; m_rd <= '0; m_nzcv <= '0;
      m_sq <= 0; m_tc <= '0; m_ntc <= '0;
    end else if (bus.stall) begin
      m_bt <= 1'b0;
    end else begin
      m_valid <= m_acc;
      m_alu   <= bus.alu_d;
      m_sd    <= bus.store_data;
      m_rd    <= bus.rd;
      m_rw    <= m_acc && bus.reg_write;
      m_mr    <= m_acc && bus.mem_read;
      m_mw    <= m_acc && bus.mem_write;
      m_bt    <= m_take;
      m_bpc   <= bus.br_target;
      if (m_acc && bus.set_flags)
        m_nzcv <= {bus.alu_n, bus.alu_z, bus.alu_cout, bus.alu_v};
      if (m_sq > 0) begin
        if (bus.flush) m_sq <= 0;
        else if (bus.in_valid) m_sq <= m_sq - 1;
      end else if (m_take) begin
        m_sq <= SQ;
      end
`ifdef BRANCH_STATS_EN
      if (m_take) m_tc <= m_tc + 32'd1;
      if (m_acc && m_isbr && !m_take) m_ntc <= m_ntc + 32'd1;
`endif
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the DUT against the model on every negative clock edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("mem_valid", 64'(bus.mem_valid), 64'(m_valid));
      check("mem_reg_write", 64'(bus.mem_reg_write), 64'(m_rw));
      check("mem_mem_read", 64'(bus.mem_mem_read), 64'(m_mr));
      check("mem_mem_write", 64'(bus.mem_mem_write), 64'(m_mw));
      check("nzcv", 64'(bus.nzcv), 64'(m_nzcv));
      check("branch_taken", 64'(bus.branch_taken), 64'(m_bt));
      check("squashing", 64'(bus.squashing), 64'(m_sq > 0));
      check("br_taken_cnt", 64'(bus.br_taken_cnt), 64'(m_tc));
      check("br_nt_cnt", 64'(bus.br_nt_cnt), 64'(m_ntc));
      if (m_valid) begin
        check("mem_alu_d", bus.mem_alu_d, m_alu);
        check("mem_rd", 64'(bus.mem_rd), 64'(m_rd));
        check("mem_store_data", bus.mem_store_data, m_sd);
      end
      if (m_bt) check("branch_pc", bus.branch_pc, m_bpc);
    end
  end

  // ------------------------------ stimulus ---------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bt: 0 none, 1 B.cond, 2 CBZ, 3 CBNZ. f is the ALU flag set as {N,Z,C,V}.
  task automatic drive(input logic v, input logic [63:0] d, input logic [3:0] f,
                       input logic sf, input int bt, input logic [3:0] c,
                       input logic [63:0] tgt);
    bus.in_valid  = v;
    bus.alu_d     = d;
    bus.alu_n     = f[3];
    bus.alu_z     = f[2];
    bus.alu_cout  = f[1];
    bus.alu_v     = f[0];
    bus.set_flags = sf;
    bus.is_bcond  = (bt == 1);
    bus.is_cbz    = (bt == 2);
    bus.is_cbnz   = (bt == 3);
    bus.cond      = c;
    bus.br_target = tgt;
    bus.rd        = d[4:0] ^ 5'd3;
    bus.reg_write = (bt == 0);
    bus.mem_read  = d[1];
    bus.mem_write = d[2];
    bus.store_data = ~d;
    step();
  endtask

  task automatic filler(input logic [63:0] d);
    drive(1'b1, d, 4'b0000, 1'b0, 0, 4'h0, 64'd0);
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive(1'b1, 64'h77, f, 1'b1, 0, 4'h0, 64'd0);
  endtask

  initial begin
    logic [3:0] flag_tab [8];
    flag_tab = '{4'b0000, 4'b0100, 4'b0010, 4'b1000, 4'b0001, 4'b1001, 4'b0110, 4'b1111};
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 64'd0, 4'b0000, 1'b0, 0, 4'h0, 64'd0);
    cmp_en = 1'b1;
    drive(1'b1, 64'h5, 4'b1111, 1'b1, 1, 4'hE, 64'h40);
    check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rst_nzcv", 64'(bus.nzcv), 64'd0);
    check("rst_squashing", 64'(bus.squashing), 64'd0);
    rst = 1'b0;

    // SUBS result 0 with carry, then B.EQ to 0x1000
    drive(1'b1, 64'd0, 4'b0110, 1'b1, 0, 4'h0, 64'd0);
    check("subs_nzcv", 64'(bus.nzcv), 64'h6);
    drive(1'b1, 64'h5, 4'b0000, 1'b0, 1, 4'h0, 64'h1000);
    check("beq_taken", 64'(bus.branch_taken), 64'd1);
    check("beq_pc", bus.branch_pc, 64'h1000);
    filler(64'h21);
    check("beq_pulse_once", 64'(bus.branch_taken), 64'd0);
    check("beq_drop1", 64'(bus.mem_valid), 64'd0);
    filler(64'h22);
    check("beq_drop2", 64'(bus.mem_valid), 64'd0);
    filler(64'h23);
    check("beq_third_passes", 64'(bus.mem_valid), 64'd1);

    // NZCV=1000, non-setting ADD keeps it; B.GE not taken; B.LT taken
    set_flags(4'b1000);
    drive(1'b1, 64'h9, 4'b0000, 1'b0, 0, 4'h0, 64'd0);
    check("add_keeps_nzcv", 64'(bus.nzcv), 64'h8);
    drive(1'b1, 64'h9, 4'b0000, 1'b0, 1, 4'hA, 64'h2000);
    check("bge_not_taken", 64'(bus.branch_taken), 64'd0);
    drive(1'b1, 64'h9, 4'b0000, 1'b0, 1, 4'hB, 64'h3000);
    check("blt_taken", 64'(bus.branch_taken), 64'd1);
    filler(64'h31); filler(64'h32);

    // CBNZ of zero is not taken, CBZ of zero is taken; a bubble inside the squash
    drive(1'b1, 64'd0, 4'b0000, 1'b0, 3, 4'h0, 64'h4000);
    check("cbnz_zero_nt", 64'(bus.branch_taken), 64'd0);
    drive(1'b1, 64'd0, 4'b0000, 1'b0, 2, 4'h0, 64'hDEAD_BEEF_0000_0040);
    check("cbz_zero_taken", 64'(bus.branch_taken), 64'd1);
    check("cbz_pc", bus.branch_pc, 64'hDEAD_BEEF_0000_0040);
    drive(1'b0, 64'h1, 4'b0000, 1'b0, 0, 4'h0, 64'd0);
    filler(64'h41); filler(64'h42); filler(64'h43);

    // Stall for 3 cycles during SQUASH
    drive(1'b1, 64'h8, 4'b0000, 1'b0, 1, 4'hE, 64'h5000);
    bus.stall = 1'b1;
    filler(64'h51);
    check("stall_no_pulse", 64'(bus.branch_taken), 64'd0);
    filler(64'h52); filler(64'h53);
    check("stall_still_squash", 64'(bus.squashing), 64'd1);
    bus.stall = 1'b0;
    filler(64'h54);
    check("stall_squash_1", 64'(bus.squashing), 64'd1);
    filler(64'h55);
    check("stall_squash_done", 64'(bus.squashing), 64'd0);

    // Flush together with a taken branch: no pulse, no SQUASH
    bus.flush = 1'b1;
    drive(1'b1, 64'h8, 4'b0000, 1'b0, 1, 4'hF, 64'h6000);
    check("flush_br_no_pulse", 64'(bus.branch_taken), 64'd0);
    check("flush_br_no_squash", 64'(bus.squashing), 64'd0);
    bus.flush = 1'b0;
    // Flush while squashing exits at once
    drive(1'b1, 64'h8, 4'b0000, 1'b0, 1, 4'hE, 64'h7000);
    bus.flush = 1'b1;
    filler(64'h61);
    check("flush_exits_squash", 64'(bus.squashing), 64'd0);
    bus.flush = 1'b0;
    filler(64'h62);
    check("after_flush_accept", 64'(bus.mem_valid), 64'd1);

    // Sweep all condition codes over several flag values
    foreach (flag_tab[i]) begin
      set_flags(flag_tab[i]);
      for (int c = 0; c < 16; c++) begin
        drive(1'b1, 64'(c + 1), 4'b0000, 1'b0, 1, 4'(c), 64'(c * 16));
        filler(64'h70); filler(64'h71);
      end
    end

    // Reset while squashing with one drop left
    drive(1'b1, 64'h8, 4'b0000, 1'b0, 1, 4'hE, 64'h8000);
    filler(64'h81);
    check("pre_rst_squash", 64'(bus.squashing), 64'd1);
    rst = 1'b1;
    filler(64'h82);
    check("rst_sq_squashing", 64'(bus.squashing), 64'd0);
    check("rst_sq_valid", 64'(bus.mem_valid), 64'd0);
    check("rst_sq_bt", 64'(bus.branch_taken), 64'd0);
    rst = 1'b0;
    filler(64'h83);
    check("post_rst_accept", 64'(bus.mem_valid), 64'd1);

    // Statistics: 5 taken and 3 not-taken since reset
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 64'h3, 4'b0000, 1'b0, 1, 4'hE, 64'(k));
      filler(64'h90); filler(64'h91);
    end
    for (int k = 0; k < 3; k++) drive(1'b1, 64'h5, 4'b0000, 1'b0, 2, 4'h0, 64'h100);
`ifdef BRANCH_STATS_EN
    check("stats_taken", 64'(bus.br_taken_cnt), 64'd5);
    check("stats_nt", 64'(bus.br_nt_cnt), 64'd3);
`else
    check("stats_taken_off", 64'(bus.br_taken_cnt), 64'd0);
    check("stats_nt_off", 64'(bus.br_nt_cnt), 64'd0);
`endif
    drive(1'b0, 64'd0, 4'b0000, 1'b0, 0, 4'h0, 64'd0);
    step();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_flags_stage.md
Name: ex_mem_flags_stage

Overview:
- Execute-to-memory pipeline stage that sits directly downstream of the 64-bit ALU in the ARM core.
- Registers the ALU result and control bundle into the EX/MEM register.
- Holds the architectural NZCV flag register and evaluates B.cond, CBZ and CBNZ.
- Issues a one-cycle branch redirect, then squashes wrong-path instructions through a small state machine.

Parameters:
- SQUASH_CYCLES, 2, number of accepted input cycles squashed after a taken branch (1..7).
- XLEN, 64, datapath width.

Ports:
- CLK  input  1  single clock, rising edge.
- Reset  input  1  synchronous, active-high.
- Stall  input  1  hold every register; accept nothing.
- Flush  input  1  external kill of the current input instruction.
- in_valid  input  1  EX instruction present.
- alu_d  input  XLEN  ALU result.
- alu_Cout, alu_V, alu_Z, alu_N  input  1 each  ALU flags; already zero unless the ALU FLAGS input was set.
- set_flags  input  1  instruction is flag-setting (ADDS/SUBS/ANDS).
- is_bcond, is_cbz, is_cbnz  input  1 each  branch type, mutually exclusive.
- cond  input  4  B.cond condition code.
- br_target  input  XLEN  computed branch target.
- rd  input  5  destination register.
- reg_write, mem_read, mem_write  input  1 each  control bundle.
- store_data  input  XLEN  store data.
- mem_valid  output  1  EX/MEM slot valid.
- mem_alu_d  output  XLEN  registered ALU result.
- mem_rd  output  5  registered destination register.
- mem_reg_write, mem_mem_read, mem_mem_write  output  1 each  registered controls, forced to 0 when slot invalid.
- mem_store_data  output  XLEN  registered store data.
- NZCV  output  4  flag register {N,Z,C,V}.
- branch_taken  output  1  registered redirect pulse.
- branch_pc  output  XLEN  redirect target, valid with branch_taken.
- squashing  output  1  state is SQUASH.
- br_taken_cnt, br_nt_cnt  output  32 each  branch statistics (see Optional Feature).

Behaviour:
- Reset: all outputs, NZCV, counters and squash counter go to 0; state is IDLE. Reset has priority over Stall and Flush.
- Reset mid-SQUASH returns to IDLE with squash count 0.
- Accept condition: acc = in_valid & ~Stall & ~Flush & (state==IDLE).
- Stall: all state holds, and branch_taken holds 0. The pulse never repeats.
- Pipeline register, 1-cycle latency:
  - When ~Stall, mem_valid <= acc and the data fields load.
  - On any non-accepted cycle, the controls and mem_valid are 0; data fields are don't-care (implementation loads them).
- NZCV: loads {alu_N, alu_Z, alu_Cout, alu_V} iff acc & set_flags. Otherwise holds.
- Condition evaluation:
  - Uses the current NZCV register value. The prior flag-setter has already written it by the time a dependent branch is in EX.
  - Codes: 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !(C&!Z); A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE !(GT); E, F always.
- CBZ taken iff alu_d==0 (local compare). CBNZ taken iff alu_d!=0.
- take = acc & (is_bcond&cond_true | is_cbz&zero | is_cbnz&~zero).
- When ~Stall, branch_taken <= take and branch_pc <= br_target.
- State machine:
  - IDLE --take--> SQUASH with cnt=SQUASH_CYCLES.
  - In SQUASH, each cycle with in_valid & ~Stall decrements cnt; that input is dropped (mem_valid 0, no NZCV update, no branch).
  - cnt reaching 0 returns to IDLE on that same edge.
  - Flush in SQUASH returns to IDLE immediately.
- Simultaneous events: Flush with a taken branch suppresses the branch, with no pulse and no SQUASH.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: br_taken_cnt increments on each taken branch accept; br_nt_cnt increments on each accepted not-taken branch. Both are 32-bit, wrap 0xFFFFFFFF->0, and clear on Reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- SUBS result 0 with Cout=1 (set_flags=1), then B.EQ (cond=0) target 0x1000 -> NZCV=4'b0110, branch_taken=1 for exactly 1 cycle, branch_pc=0x1000, next 2 valid inputs give mem_valid=0, 3rd passes.
- ADD with alu_Z=0, set_flags=0 following an NZCV=4'b1000 -> NZCV stays 4'b1000; B.LT taken, B.GE not taken.
- CBNZ alu_d=0x0 -> not taken; CBZ alu_d=0x0 -> taken; branch_pc matches br_target.
- Taken branch with Stall high for 3 cycles during SQUASH -> cnt unchanged; branch_taken not re-asserted; squash completes after 2 unstalled valid cycles.
- Reset asserted while squashing=1 with cnt=1 -> next cycle all outputs 0, state IDLE, next input accepted.
- BRANCH_STATS_EN defined: 5 taken, 3 not-taken branches -> br_taken_cnt=5, br_nt_cnt=3. Undefined -> both read 0.
